// File: rtl/counter_pkg.sv
// counter_pkg: default constants and the per-edge action type shared by the counter files.
// The COUNTER_FREERUN_EN macro, when defined, lets an active-low i_Reset request free-run counting.
package counter_pkg;

    localparam int COUNTER_WIDTH_DEF = 12;
    localparam int TWO_SEC_COUNT_DEF = 4000;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_INC   = 2'd1,
        ACT_CLEAR = 2'd2
    } act_e;

    function automatic act_e pick_act(input logic clear, input logic inc);
        return clear ? ACT_CLEAR : (inc ? ACT_INC : ACT_HOLD);
    endfunction

endpackage

// File: rtl/counter_flag.sv
// counter_flag: sticky two-second flag, set when an increment lands on TWO_SEC_COUNT.
// The flag stays set until a clear.
module counter_flag
    import counter_pkg::*;
#(
    parameter int WIDTH         = COUNTER_WIDTH_DEF,
    parameter int TWO_SEC_COUNT = TWO_SEC_COUNT_DEF
) (
    input  logic             clk_2K,
    input  act_e             act,
    input  logic [WIDTH-1:0] count_d,
    output logic             o_TwoSec
);

    logic hit;
    logic flag_d;
    logic flag_q;

    always_comb begin
        hit    = (act == ACT_INC) && (count_d == WIDTH'(TWO_SEC_COUNT));
        flag_d = (act == ACT_CLEAR) ? 1'b0 : (flag_q | hit);
    end

    always_ff @(posedge clk_2K) begin
        flag_q <= flag_d;
    end

    assign o_TwoSec = flag_q;

endmodule

// File: rtl/counter.sv
// counter: registered wrap-around counter with clear > increment > hold priority.
// Define COUNTER_FREERUN_EN to let i_Reset=0 also advance the count.
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH         = COUNTER_WIDTH_DEF,
    parameter int TWO_SEC_COUNT = TWO_SEC_COUNT_DEF
) (
    input  logic             clk_2K,
    input  logic             i_RstCounter,
    input  logic             i_ActCounter,
    input  logic             i_Reset,
    output logic [WIDTH-1:0] o_Count,
    output logic             o_TwoSec
);

    logic             inc;
    act_e             act;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

`ifdef COUNTER_FREERUN_EN
    assign inc = i_ActCounter | ~i_Reset;
`else
    logic unused_reset;
    assign unused_reset = i_Reset;
    assign inc          = i_ActCounter;
`endif

    always_comb begin
        act     = pick_act(i_RstCounter, inc);
        count_d = (act == ACT_CLEAR) ? '0 :
                  (act == ACT_INC)   ? count_q + WIDTH'(1) : count_q;
    end

    always_ff @(posedge clk_2K) begin
        count_q <= count_d;
    end

    counter_flag #(
        .WIDTH        (WIDTH),
        .TWO_SEC_COUNT(TWO_SEC_COUNT)
    ) u_flag (
        .clk_2K  (clk_2K),
        .act     (act),
        .count_d (count_d),
        .o_TwoSec(o_TwoSec)
    );

    assign o_Count = count_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: random and directed stimulus against an increment-tally model of the counter.
module tb_counter;

    localparam int W   = 12;
    localparam int TSC = 4000;
    localparam int MOD = 1 << W;

`ifdef COUNTER_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic         clk_2K = 1'b0;
    logic         i_RstCounter = 1'b0;
    logic         i_ActCounter = 1'b0;
    logic         i_Reset = 1'b1;
    logic [W-1:0] o_Count;
    logic         o_TwoSec;

    int total = 0;
    int bad   = 0;
    int n_inc = 0;

    counter #(.WIDTH(W), .TWO_SEC_COUNT(TSC)) dut (
        .clk_2K      (clk_2K),
        .i_RstCounter(i_RstCounter),
        .i_ActCounter(i_ActCounter),
        .i_Reset     (i_Reset),
        .o_Count     (o_Count),
        .o_TwoSec    (o_TwoSec)
    );

    always #5 clk_2K = ~clk_2K;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Count and flag follow only from the number of increments since the last clear.
    task automatic step(input string tag, input logic rst, input logic act, input logic rstn);
        i_RstCounter = rst;
        i_ActCounter = act;
        i_Reset      = rstn;
        @(posedge clk_2K);
        if (rst) n_inc = 0;
        else if (act || (FREERUN && !rstn)) n_inc++;
        #1;
        check({tag, ".count"}, int'(o_Count), n_inc % MOD);
        check({tag, ".flag"}, int'(o_TwoSec), int'(n_inc >= TSC));
    endtask

    initial begin
        int n;
        int hold_val;
        step("reset", 1, 0, 1);
        step("reset2", 1, 1, 0);

        n = $urandom_range(4499, 0);
        for (int i = 0; i < n; i++) step("freerun", 0, 0, 0);
        check("freerun.final", int'(o_Count), FREERUN ? n % MOD : 0);

        step("clr", 1, 0, 1);
        for (int i = 0; i < MOD; i++) step("twosec", 0, 1, 1);
        check("twosec.wrap", int'(o_Count), 0);
        check("twosec.flag", int'(o_TwoSec), 1);

        for (int i = 0; i < 100; i++) step("sticky", 0, 0, 1);
        check("sticky.flag", int'(o_TwoSec), 1);
        step("sticky.clr", 1, 0, 1);
        check("sticky.cleared", int'(o_TwoSec), 0);

        for (int i = 0; i < 10; i++) step("hold.up", 0, 1, 1);
        for (int i = 0; i < 50; i++) step("hold", 0, 0, 1);
        check("hold.count", int'(o_Count), 10);
        check("hold.flag", int'(o_TwoSec), 0);

        step("prio.clr", 1, 0, 1);
        for (int i = 0; i < TSC - 1; i++) step("prio.up", 0, 1, 1);
        check("prio.3999", int'(o_Count), TSC - 1);
        step("prio", 1, 1, 0);
        check("prio.count", int'(o_Count), 0);
        check("prio.flag", int'(o_TwoSec), 0);

        for (int i = 0; i < 5; i++) step("both", 0, 1, 0);
        check("both.count", int'(o_Count), 5);

        hold_val = int'(o_Count);
        for (int i = 0; i < 20; i++) step("rstn_only", 0, 0, 0);
        check("rstn_only.count", int'(o_Count), FREERUN ? hold_val + 20 : hold_val);

        for (int i = 0; i < 3000; i++)
            step("rand", ($urandom_range(99, 0) == 0), 1'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 12, counter width in bits (SHALL be 2..32).
REQ-002 Parameter TWO_SEC_COUNT, default 4000, count value marking 2 s at 2 kHz (SHALL be 1..2^WIDTH-1).
REQ-003 clk_2K  input  1  sole clock, 2 kHz, all logic on rising edge.
REQ-004 i_RstCounter  input  1  reset: synchronous, active-high; clears count and flag.
REQ-005 i_ActCounter  input  1  active-high count enable.
REQ-006 i_Reset  input  1  active-low player-reset free-run request; count advances while low.
REQ-007 o_Count  output  WIDTH  current registered count value.
REQ-008 o_TwoSec  output  1  registered flag: TWO_SEC_COUNT enabled cycles elapsed since last clear.

Function
REQ-009 Priority per rising edge SHALL be: i_RstCounter, then increment, then hold.
REQ-010 Increment condition SHALL be (i_ActCounter == 1) OR (i_Reset == 0); the count SHALL advance by exactly 1 per qualifying edge.
REQ-011 Increment SHALL wrap modulo 2^WIDTH (2^WIDTH-1 -> 0); no saturation.
REQ-012 o_Count SHALL change only on the rising edge; latency from qualifying edge to new o_Count is 1 cycle.
REQ-013 o_TwoSec SHALL be set on the edge where an increment produces o_Count == TWO_SEC_COUNT.
REQ-014 o_TwoSec SHALL stay set (sticky) through further counting, wrap-around and enable deassertion until i_RstCounter.
REQ-015 i_RstCounter together with either enable SHALL clear; the clear wins.
REQ-016 With both enables inactive, o_Count and o_TwoSec SHALL hold.
REQ-017 Simultaneous i_ActCounter=1 and i_Reset=0 SHALL still advance by exactly 1.

Reset
REQ-018 On i_RstCounter=1 at a rising edge: o_Count = 0, o_TwoSec = 0 after that edge.
REQ-019 No asynchronous reset SHALL exist; before the first reset edge the outputs are undefined.
REQ-020 Reset asserted mid-count SHALL discard the count; counting resumes from 0 on the first qualifying edge after release.

Configuration
REQ-021 Macro COUNTER_FREERUN_EN SHALL control the i_Reset free-run feature.
REQ-022 With COUNTER_FREERUN_EN defined, REQ-010 applies in full.
REQ-023 Without COUNTER_FREERUN_EN, the port i_Reset SHALL remain but be ignored, and only i_ActCounter SHALL enable counting.
REQ-024 The default project build SHALL define COUNTER_FREERUN_EN.

Structure
REQ-025 Package counter_pkg SHALL hold the default constants COUNTER_WIDTH_DEF=12 and TWO_SEC_COUNT_DEF=4000.
REQ-026 Sub-module counter_flag SHALL implement the terminal-compare and sticky-flag logic, instantiated once.
REQ-027 The remaining logic SHALL be a single registered counter in counter.

Verification
REQ-028 Free-run: clear, then i_Reset=0, i_ActCounter=0 for N edges (N random 0..4499) -> o_Count == N mod 4096.
REQ-029 Two-second: clear, then i_ActCounter=1, i_Reset=1 for 4096 edges -> o_TwoSec=1 (set at count 4000), o_Count=0 after wrap.
REQ-030 Hold: count to 10, then both enables inactive for 50 edges -> o_Count stays 10, o_TwoSec=0.
REQ-031 Clear priority: count 3999, assert i_RstCounter with i_ActCounter=1 -> o_Count=0, o_TwoSec=0 next edge.
REQ-032 Sticky: after o_TwoSec=1, drop i_ActCounter for 100 edges -> o_TwoSec stays 1 until i_RstCounter.
REQ-033 Macro off: i_Reset=0, i_ActCounter=0 for 20 edges -> o_Count unchanged.
